// File: rtl/adc_scan_scheduler_if.sv
// adc_scan_scheduler_if: control, ADC pin and result/readout signals of the scan scheduler
interface adc_scan_scheduler_if;
    logic        enable;
    logic [7:0]  ch_mask;
    logic        adc_sclk;
    logic        adc_cs_n;
    logic        adc_din;
    logic        adc_dout;
    logic        res_valid;
    logic [2:0]  res_ch;
    logic [11:0] res_data;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;
    logic        busy;
    modport master (output enable, ch_mask, adc_dout, rd_addr,
                    input  adc_sclk, adc_cs_n, adc_din, res_valid, res_ch, res_data, rd_data, busy);
    modport slave  (input  enable, ch_mask, adc_dout, rd_addr,
                    output adc_sclk, adc_cs_n, adc_din, res_valid, res_ch, res_data, rd_data, busy);
endinterface

// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: round-robin 8-channel serial ADC scanner with per-channel result table; ADC_SCHED_AVG_EN enables 4-sample averaging
module adc_scan_scheduler #(
    parameter int CLK_DIV     = 2,
    parameter int CONV_CYCLES = 80
) (
    input logic                 clk,
    input logic                 reset,
    adc_scan_scheduler_if.slave bus
);
    localparam int CW = $clog2(CONV_CYCLES > CLK_DIV ? CONV_CYCLES : CLK_DIV);
    typedef enum logic [1:0] {IDLE, CONV, SHIFT, GAP} state_t;
    state_t      state, state_n;
    logic [CW-1:0] cnt;
    logic [3:0]  bit_idx;
    logic        sclk_hi, prev_valid, go, conv_done, half_done, rise, shift_done, store;
    logic [2:0]  cur_ch, prev_ch, pick;
    logic [11:0] shift_r, store_data, din_seq;
    logic [11:0] tbl [8];

    assign go         = bus.enable && |bus.ch_mask;
    assign conv_done  = cnt == CW'(CONV_CYCLES - 1);
    assign half_done  = cnt == CW'(CLK_DIV - 1);
    assign rise       = state == SHIFT && half_done && !sclk_hi;
    assign shift_done = half_done && sclk_hi && bit_idx == 4'd11;
    assign din_seq    = {1'b1, cur_ch[0], cur_ch[2], cur_ch[1], 2'b10, 6'b0};

    // next enabled channel after cur_ch, wrapping; falls back to cur_ch when it is the only one set
    always_comb begin
        pick = cur_ch;
        for (int i = 7; i >= 1; i--)
            if (bus.ch_mask[cur_ch + 3'(i)]) pick = cur_ch + 3'(i);
    end

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else state <= state_n;

    // next state and pin/result outputs, all decoded from registered state
    always_comb begin
        state_n = state == IDLE  ? (go ? CONV : IDLE) :
                  state == CONV  ? (conv_done ? SHIFT : CONV) :
                  state == SHIFT ? (shift_done ? GAP : SHIFT) :
                                   (go ? CONV : IDLE);
        bus.adc_cs_n  = state != SHIFT;
        bus.adc_sclk  = state == SHIFT && sclk_hi;
        bus.adc_din   = state == SHIFT && din_seq[4'd11 - bit_idx];
        bus.busy      = state != IDLE;
        bus.res_valid = store;
        bus.res_ch    = store ? prev_ch : 3'd0;
        bus.res_data  = store ? store_data : 12'd0;
    end

    // phase timing, serial shift-in and the one-frame-late channel pipeline
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt        <= '0;
            bit_idx    <= '0;
            sclk_hi    <= 1'b0;
            cur_ch     <= 3'd7;
            prev_ch    <= 3'd0;
            prev_valid <= 1'b0;
            shift_r    <= '0;
        end else begin
            cnt <= (state_n != state || state == IDLE || (state == SHIFT && half_done)) ? '0 : cnt + 1'b1;
            if (state == CONV) begin
                sclk_hi <= 1'b0;
                bit_idx <= '0;
            end else if (state == SHIFT && half_done) begin
                sclk_hi <= !sclk_hi;
                if (sclk_hi) bit_idx <= bit_idx + 1'b1;
            end
            if (rise) shift_r <= {shift_r[10:0], bus.adc_dout};
            if ((state == IDLE || state == GAP) && go) cur_ch <= pick;
            if (state == GAP) begin
                prev_ch    <= cur_ch;
                prev_valid <= go;
            end
        end

`ifdef ADC_SCHED_AVG_EN
    logic [13:0] acc [8];
    logic [1:0]  nsamp [8];
    logic [13:0] sum;
    assign sum        = acc[prev_ch] + 14'(shift_r);
    assign store      = state == GAP && prev_valid && nsamp[prev_ch] == 2'd3;
    assign store_data = sum[13:2];

    // accumulate each result; the 4th sample of a channel publishes the mean and restarts
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                acc[i]   <= '0;
                nsamp[i] <= '0;
            end
        end else if (state == GAP && prev_valid) begin
            acc[prev_ch]   <= store ? 14'd0 : sum;
            nsamp[prev_ch] <= nsamp[prev_ch] + 1'b1;
        end
`else
    assign store      = state == GAP && prev_valid;
    assign store_data = shift_r;
`endif

    // latest-result table with registered read port (read-before-write on collision)
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            for (int i = 0; i < 8; i++) tbl[i] <= '0;
            bus.rd_data <= '0;
        end else begin
            if (store) tbl[prev_ch] <= store_data;
            bus.rd_data <= tbl[bus.rd_addr];
        end
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// tb_adc_scan_scheduler: randomized scan scheduler bench with ADC pin model and result scoreboard
module tb_adc_scan_scheduler;
    localparam int CLK_DIV = 2, CONV_CYCLES = 80;
    logic clk = 1'b0, reset = 1'b1;
    adc_scan_scheduler_if bus();
    adc_scan_scheduler #(.CLK_DIV(CLK_DIV), .CONV_CYCLES(CONV_CYCLES)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct { logic [2:0] ch; logic [11:0] data; } res_t;
    res_t        exp_q[$];
    int          vectors = 0, miscompares = 0, cyc = 0, frames = 0;
    int          k = 0, t_pick = 0, t_fall = 0;
    logic        m_idle = 1'b1, m_prev_valid = 1'b0, cs_q = 1'b1, sclk_q = 1'b0;
    logic [2:0]  m_cur = 3'd7, m_prev_ch = 3'd0, exp_ch = 3'd0;
    logic [11:0] m_tbl [8];
    logic [5:0]  cmd_bits = 6'd0;
    logic [11:0] word = 12'd0, fixed_val = 12'd0;
    logic        fixed_en = 1'b0;
`ifdef ADC_SCHED_AVG_EN
    int          m_acc [8], m_n [8];
`endif

    function automatic void chk(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [2:0] next_pick(logic [7:0] mask, logic [2:0] cur);
        for (int i = 1; i <= 8; i++)
            if (mask[3'((int'(cur) + i) % 8)]) return 3'((int'(cur) + i) % 8);
        return cur;
    endfunction

    function automatic logic [5:0] cmd_of(logic [2:0] c);
        return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
    endfunction

    function automatic void frame_end();
        logic [2:0] c;
        chk("sclk_periods", k, 12);
        chk("shift_len", cyc - t_fall, 24 * CLK_DIV);
        chk("cmd_word", int'(cmd_bits), int'(cmd_of(exp_ch)));
        c = m_prev_ch;
        if (m_prev_valid) begin
`ifdef ADC_SCHED_AVG_EN
            m_acc[c] += int'(word);
            m_n[c]++;
            if (m_n[c] == 4) begin
                exp_q.push_back('{c, 12'(m_acc[c] / 4)});
                m_tbl[c] = 12'(m_acc[c] / 4);
                m_acc[c] = 0;
                m_n[c]   = 0;
            end
`else
            exp_q.push_back('{c, word});
            m_tbl[c] = word;
`endif
        end
        m_prev_ch    = exp_ch;
        m_prev_valid = bus.enable && bus.ch_mask != 8'd0;
        if (m_prev_valid) begin
            exp_ch = next_pick(bus.ch_mask, m_cur);
            m_cur  = exp_ch;
            t_pick = cyc;
        end else m_idle = 1'b1;
        frames++;
    endfunction

    always @(posedge clk) cyc++;

    // ADC device model plus high-level schedule model, sampled mid-cycle
    always @(negedge clk) begin
        if (reset) begin
            cs_q   = 1'b1;
            sclk_q = 1'b0;
            k      = 0;
        end else begin
            chk("busy", int'(bus.busy), int'(!m_idle));
            if (!bus.adc_cs_n && cs_q) begin
                chk("conv_time", cyc - t_pick, CONV_CYCLES + 1);
                word     = fixed_en ? fixed_val : 12'($urandom_range(0, 4095));
                k        = 0;
                cmd_bits = 6'd0;
                t_fall   = cyc;
            end
            if (!bus.adc_cs_n) begin
                if (bus.adc_sclk && !sclk_q) begin
                    if (k < 6) cmd_bits = {cmd_bits[4:0], bus.adc_din};
                    else chk("din_tail", int'(bus.adc_din), 0);
                    k++;
                end
                bus.adc_dout = k < 12 ? word[4'(11 - k)] : 1'b0;
            end else begin
                chk("sclk_idle", int'(bus.adc_sclk), 0);
                if (!cs_q) frame_end();
                else if (m_idle && bus.enable && bus.ch_mask != 8'd0) begin
                    exp_ch = next_pick(bus.ch_mask, m_cur);
                    m_cur  = exp_ch;
                    m_idle = 1'b0;
                    t_pick = cyc;
                end
            end
            cs_q   = bus.adc_cs_n;
            sclk_q = bus.adc_sclk;
        end
    end

    // result monitor: every strobe must match the oldest expected result
    always @(negedge clk) begin
        res_t e;
        #1;
        if (!reset && bus.res_valid) begin
            chk("strobe_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("res_ch", int'(bus.res_ch), int'(e.ch));
                chk("res_data", int'(bus.res_data), int'(e.data));
            end
        end
    end

    task automatic set_in(logic en, logic [7:0] m);
        @(posedge clk);
        #1;
        bus.enable  = en;
        bus.ch_mask = m;
    endtask

    task automatic do_reset(bit mid);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        if (mid) begin
            chk("rst_cs_n", int'(bus.adc_cs_n), 1);
            chk("rst_sclk", int'(bus.adc_sclk), 0);
            chk("rst_din", int'(bus.adc_din), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_res_valid", int'(bus.res_valid), 0);
        end
        exp_q.delete();
        m_idle       = 1'b1;
        m_prev_valid = 1'b0;
        m_cur        = 3'd7;
        m_prev_ch    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            m_tbl[i] = 12'd0;
`ifdef ADC_SCHED_AVG_EN
            m_acc[i] = 0;
            m_n[i]   = 0;
`endif
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_frames(int n);
        int target = frames + n;
        for (int i = 0; i < n * 200 + 400; i++) begin
            if (frames >= target) break;
            @(posedge clk);
        end
        chk("frame_timeout", int'(frames >= target), 1);
    endtask

    task automatic wait_cs(logic lvl);
        for (int i = 0; i < 400; i++) begin
            if (bus.adc_cs_n == lvl) break;
            @(posedge clk);
        end
        chk("cs_timeout", int'(bus.adc_cs_n), int'(lvl));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400; i++) begin
            if (m_idle) break;
            @(posedge clk);
        end
        chk("idle_timeout", int'(m_idle), 1);
        repeat (3) @(posedge clk);
    endtask

    task automatic check_table();
        for (int a = 0; a < 8; a++) begin
            @(posedge clk);
            #1 bus.rd_addr = 3'(a);
            @(posedge clk);
            #2 chk($sformatf("table[%0d]", a), int'(bus.rd_data), int'(m_tbl[a]));
        end
    endtask

    initial begin
        bus.enable   = 1'b0;
        bus.ch_mask  = 8'd0;
        bus.rd_addr  = 3'd0;
        bus.adc_dout = 1'b0;
        do_reset(1'b0);
        check_table();
        fixed_en  = 1'b1;
        fixed_val = 12'hA5C;
        set_in(1'b1, 8'h04);
        wait_frames(4);
        fixed_en = 1'b0;
        set_in(1'b1, 8'h91);
        wait_frames(7);
        set_in(1'b0, 8'h91);
        wait_idle();
        check_table();
        set_in(1'b1, 8'h00);
        repeat (60) @(posedge clk);
        set_in(1'b1, 8'h3C);
        wait_frames(2);
        wait_cs(1'b1);
        repeat (20) @(posedge clk);
        set_in(1'b0, 8'h3C);
        wait_idle();
        check_table();
        set_in(1'b1, 8'h01);
        wait_frames(2);
        wait_cs(1'b0);
        repeat (7) @(posedge clk);
        set_in(1'b1, 8'h02);
        wait_frames(3);
        wait_cs(1'b0);
        repeat (10) @(posedge clk);
        do_reset(1'b1);
        check_table();
        for (int it = 0; it < 25; it++) begin
            set_in($urandom_range(0, 3) != 0, 8'($urandom));
            repeat ($urandom_range(1, 400)) @(posedge clk);
            if (!bus.enable) begin
                wait_idle();
                check_table();
            end
        end
        set_in(1'b0, 8'h00);
        wait_idle();
        check_table();
        chk("pending_results", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
